// File: rtl/sprite_palette_pkg.sv
// Shared types and reset-time colour table for the sprite palette engine.
package sprite_palette_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FLASH_ON  = 2'd1,
        FLASH_OFF = 2'd2
    } flash_state_t;

    localparam int FLASH_CNT_W = 8;

    // 4-bit-per-channel {r,g,b} colours loaded into every bank at reset
    localparam logic [11:0] DEFAULT_PALETTE [16] = '{
        12'hF0F, 12'h000, 12'hFFF, 12'h373,
        12'hF00, 12'h0F0, 12'h00F, 12'h888,
        12'hC96, 12'h5A5, 12'hA5A, 12'hE1E,
        12'h123, 12'h456, 12'h789, 12'hABC
    };

endpackage

// File: rtl/sprite_palette_engine_if.sv
// Lookup, palette-write and flash-control signals of the sprite palette engine.
interface sprite_palette_engine_if #(
    parameter int IDX_W     = 4,
    parameter int NUM_BANKS = 2,
    parameter int COLOR_W   = 4
);
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    logic                 px_valid;
    logic [IDX_W-1:0]     index;
    logic [BANK_W-1:0]    bank;
    logic                 wr_en;
    logic [BANK_W-1:0]    wr_bank;
    logic [IDX_W-1:0]     wr_idx;
    logic [3*COLOR_W-1:0] wr_rgb;
    logic                 frame_tick;
    logic                 flash_start;
    logic                 out_valid;
    logic [COLOR_W-1:0]   red;
    logic [COLOR_W-1:0]   green;
    logic [COLOR_W-1:0]   blue;
    logic                 transparent;
    logic                 flash_active;

    modport master (
        output px_valid, index, bank, wr_en, wr_bank, wr_idx, wr_rgb,
               frame_tick, flash_start,
        input  out_valid, red, green, blue, transparent, flash_active
    );

    modport slave (
        input  px_valid, index, bank, wr_en, wr_bank, wr_idx, wr_rgb,
               frame_tick, flash_start,
        output out_valid, red, green, blue, transparent, flash_active
    );

endinterface

// File: rtl/palette_flash_fsm.sv
// Hit-flash sequencer: alternates FLASH_ON/FLASH_OFF once per frame tick for FLASH_FRAMES ticks.
module palette_flash_fsm
    import sprite_palette_pkg::*;
#(
    parameter int FLASH_FRAMES = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         frame_tick,
    input  logic         flash_start,
    output flash_state_t state,
    output logic         flash_active
);

    flash_state_t           state_n;
    logic [FLASH_CNT_W-1:0] cnt;
    logic [FLASH_CNT_W-1:0] cnt_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            flash_active <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            flash_active <= (state_n != IDLE);
        end
    end

    // A restart takes priority over a coincident tick, so it never loses a frame
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (flash_start) begin
            state_n = FLASH_ON;
            cnt_n   = FLASH_CNT_W'(FLASH_FRAMES);
        end else if (frame_tick && state != IDLE) begin
            if (cnt > 8'd1) begin
                cnt_n   = cnt - 8'd1;
                state_n = (state == FLASH_ON) ? FLASH_OFF : FLASH_ON;
            end else begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        end
    end

endmodule

// File: rtl/sprite_palette_engine.sv
// Two-stage banked palette lookup with transparency and hit-flash override.
module sprite_palette_engine
    import sprite_palette_pkg::*;
#(
    parameter int IDX_W           = 4,
    parameter int NUM_BANKS       = 2,
    parameter int COLOR_W         = 4,
    parameter int FLASH_FRAMES    = 8,
    parameter int TRANSPARENT_IDX = 0
) (
    input logic                    clk,
    input logic                    rst,
    sprite_palette_engine_if.slave bus
);

    localparam int BANK_W  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int ENTRIES = 2 ** IDX_W;
    localparam int RGB_W   = 3 * COLOR_W;

    typedef logic [RGB_W-1:0] rgb_t;

    rgb_t              pal [NUM_BANKS][ENTRIES];
    logic              vld_p1;
    logic [IDX_W-1:0]  index_p1;
    logic [BANK_W-1:0] bank_p1;
    flash_state_t      flash_state;
    rgb_t              rd_rgb_p1;
    logic              transp_p1;
    logic              flash_on_p1;

    // Left-align a 4-bit default channel into COLOR_W bits
    function automatic logic [COLOR_W-1:0] widen_nibble(input logic [3:0] n);
        logic [COLOR_W+3:0] w;
        w = {n, {COLOR_W{1'b0}}};
        return w[COLOR_W+3:4];
    endfunction

    function automatic rgb_t default_entry(input int i);
        logic [11:0] d;
        d = DEFAULT_PALETTE[i % 16];
        return {widen_nibble(d[11:8]), widen_nibble(d[7:4]), widen_nibble(d[3:0])};
    endfunction

    function automatic logic bank_ok(input logic [BANK_W-1:0] b);
        return 32'(b) < NUM_BANKS;
    endfunction

    function automatic logic [COLOR_W-1:0] flash_sat(input logic [COLOR_W-1:0] c,
                                                      input logic on);
        return on ? {COLOR_W{1'b1}} : c;
    endfunction

    // Stage 1: register the request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_p1 <= 1'b0;
        else     vld_p1 <= bus.px_valid;
    end

    always_ff @(posedge clk) begin
        index_p1 <= bus.index;
        bank_p1  <= bus.bank;
    end

    // Palette storage; out-of-range bank writes are dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NUM_BANKS; b++)
                for (int e = 0; e < ENTRIES; e++)
                    pal[b][e] <= default_entry(e);
        end else if (bus.wr_en && bank_ok(bus.wr_bank)) begin
            pal[bus.wr_bank][bus.wr_idx] <= bus.wr_rgb;
        end
    end

    // Stage 2: read (pre-write value), transparency, flash override
    assign rd_rgb_p1   = pal[bank_ok(bank_p1) ? bank_p1 : '0][index_p1];
    assign transp_p1   = (index_p1 == IDX_W'(TRANSPARENT_IDX));
    assign flash_on_p1 = (flash_state == FLASH_ON);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid   <= 1'b0;
            bus.red         <= '0;
            bus.green       <= '0;
            bus.blue        <= '0;
            bus.transparent <= 1'b0;
        end else begin
            bus.out_valid   <= vld_p1;
            bus.transparent <= vld_p1 && transp_p1;
            if (vld_p1 && !transp_p1) begin
                bus.red   <= flash_sat(rd_rgb_p1[RGB_W-1 -: COLOR_W], flash_on_p1);
                bus.green <= flash_sat(rd_rgb_p1[2*COLOR_W-1 -: COLOR_W], flash_on_p1);
                bus.blue  <= flash_sat(rd_rgb_p1[COLOR_W-1:0], flash_on_p1);
            end else begin
                bus.red   <= '0;
                bus.green <= '0;
                bus.blue  <= '0;
            end
        end
    end

    palette_flash_fsm #(
        .FLASH_FRAMES(FLASH_FRAMES)
    ) u_flash (
        .clk         (clk),
        .rst         (rst),
        .frame_tick  (bus.frame_tick),
        .flash_start (bus.flash_start),
        .state       (flash_state),
        .flash_active(bus.flash_active)
    );

endmodule

// File: doc/sprite_palette_engine.md
SPRITE_PALETTE_ENGINE -- requirements
Module: sprite_palette_engine

Interface
REQ-001 Parameter IDX_W, default 4: width of the pixel colour index; each bank holds 2**IDX_W entries.
REQ-002 Parameter NUM_BANKS, default 2: number of palette banks, used for per-player colour swap.
REQ-003 Parameter COLOR_W, default 4: width of each of the red, green and blue channels.
REQ-004 Parameter FLASH_FRAMES, default 8: number of frame ticks in one hit-flash sequence; legal range 1 to 255.
REQ-005 Parameter TRANSPARENT_IDX, default 0: index value that marks a transparent pixel.
REQ-006 Clk  input  1  single clock for the whole block.
REQ-007 Reset  input  1  asynchronous, active-high reset.
REQ-008 px_valid  input  1  a lookup request is present this cycle.
REQ-009 index  input  IDX_W  colour index of the requested pixel.
REQ-010 bank  input  BANK_W = max(1, clog2(NUM_BANKS))  bank selected for the lookup.
REQ-011 wr_en  input  1  palette write strobe.
REQ-012 wr_bank  input  BANK_W  bank to write.
REQ-013 wr_idx  input  IDX_W  entry to write.
REQ-014 wr_rgb  input  3*COLOR_W  colour to write, packed as {r,g,b}.
REQ-015 frame_tick  input  1  one-cycle pulse at each frame boundary.
REQ-016 flash_start  input  1  one-cycle pulse that starts or restarts the hit flash.
REQ-017 out_valid  output  1  red/green/blue/transparent are valid this cycle.
REQ-018 red, green, blue  output  COLOR_W each  looked-up colour channels.
REQ-019 transparent  output  1  the looked-up pixel is transparent.
REQ-020 flash_active  output  1  the flash state machine is not IDLE.

Function
REQ-021 Lookup latency SHALL be exactly 2 cycles: px_valid high at edge N gives out_valid high at edge N+2. Lookups are fully pipelined, one per cycle, with no stalls.
REQ-022 Stage 1 SHALL register index, bank and px_valid. Stage 2 SHALL read the palette, apply transparency and flash, and register the outputs.
REQ-023 When out_valid is 0, red, green, blue and transparent SHALL be 0.
REQ-024 When the stage-1 index equals TRANSPARENT_IDX, transparent SHALL be 1 and the colour outputs SHALL be 0, regardless of flash state.
REQ-025 For non-transparent pixels in state FLASH_ON, every channel SHALL be all-ones. In any other state the channels SHALL equal the stored entry.
REQ-026 Writes SHALL take effect at the clock edge where wr_en is high.
REQ-027 A stage-2 read of the same bank/entry at that same edge SHALL return the old value (read-before-write).
REQ-028 Any write or read with bank >= NUM_BANKS: the write SHALL be ignored and the read SHALL use bank 0.
REQ-029 The flash state machine SHALL have three states: IDLE, FLASH_ON and FLASH_OFF. The frame counter SHALL be 8 bits.
REQ-030 flash_start in any state SHALL load the counter with FLASH_FRAMES and enter FLASH_ON.
REQ-031 frame_tick in FLASH_ON or FLASH_OFF with counter > 1 SHALL decrement the counter and toggle between FLASH_ON and FLASH_OFF.
REQ-032 frame_tick in FLASH_ON or FLASH_OFF with counter == 1 SHALL clear the counter and enter IDLE.
REQ-033 frame_tick in IDLE SHALL have no effect.
REQ-034 If flash_start and frame_tick arrive in the same cycle, flash_start SHALL win and no decrement SHALL occur.
REQ-035 flash_active SHALL be registered and SHALL be high exactly when the state is FLASH_ON or FLASH_OFF.
REQ-036 Flash state SHALL be sampled in stage 2, so a state change affects pixels that reach stage 2 in the following cycle.

Reset
REQ-037 On Reset, every bank SHALL be loaded with DEFAULT_PALETTE.
REQ-038 On Reset, both pipeline valid bits and all outputs SHALL be 0.
REQ-039 On Reset, the flash state machine SHALL go to IDLE with the counter at 0.
REQ-040 A Reset asserted mid-flash or mid-pipeline SHALL discard all in-flight lookups; no out_valid pulse SHALL follow the release of reset.

Structure
REQ-041 Package sprite_palette_pkg SHALL hold the flash_state_t enum.
REQ-042 sprite_palette_pkg SHALL hold DEFAULT_PALETTE, a 16 x 12-bit table in which entry 0 = F0F, entry 3 = 373, entry 8 = C96 and entry 11 = E1E.
REQ-043 Sub-module palette_flash_fsm SHALL contain the flash state machine and counter. The palette storage and pipeline SHALL live in the top module.

Verification
REQ-044 Default read: after reset, px_valid=1, index=3, bank=1 -> two cycles later out_valid=1, rgb=3/7/3, transparent=0.
REQ-045 Transparent pixel: index=0 -> transparent=1, rgb=0/0/0, also while flash_active=1.
REQ-046 Write collision: wr_en with bank 1, idx 8, wr_rgb=123, and a read of bank 1 idx 8 at stage 2 in the same cycle -> that read returns C96; a read of the same entry next cycle returns 1/2/3; bank 0 entry 8 still returns C96.
REQ-047 Flash sequence: flash_start followed by 8 frame_ticks -> index 8 outputs F/F/F, C96 and F/F/F alternately per interval; IDLE and flash_active=0 after the 8th tick.
REQ-048 Flash restart: flash_start and frame_tick in the same cycle with counter=3 -> counter reloads to 8, state FLASH_ON.
REQ-049 Reset mid-operation: Reset asserted during FLASH_OFF with a modified bank 1 and 2 lookups in flight -> out_valid stays 0 after release, flash_active=0, bank 1 entry 8 reads C96.
